// File: rtl/accumulator_sequencer.sv
// accumulator_sequencer: command sequencer driving load strobes and bus enables for an accumulator datapath; ports: clk, rst_n, cmd_valid/cmd_op/cmd_data/cmd_ready command handshake, bus_in/cf_in/zf_in datapath inputs, data_out/data_oe/nla/nlb/ea/eu/sub datapath controls, done/err completion, result/cf_q/zf_q captured values; optional macro SEQ_FLAGS_EN enables flag capture
module accumulator_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic [7:0] bus_in,
  input  logic       cf_in,
  input  logic       zf_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       nla,
  output logic       nlb,
  output logic       ea,
  output logic       eu,
  output logic       sub,
  output logic       done,
  output logic       err,
  output logic [7:0] result,
  output logic       cf_q,
  output logic       zf_q
);
  localparam logic [2:0] OP_LDA = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3, OP_OUT = 3'd4;
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, OUTA, DONE} state_t;
  state_t state, state_d, dispatch;
  logic [2:0] op_q;
  logic [7:0] data_q;
  logic hs;
  assign hs = cmd_valid && state == IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= '0;
      data_q <= '0;
      result <= '0;
    end else begin
      state <= state_d;
      if (hs) begin
        op_q   <= cmd_op;
        data_q <= cmd_data;
      end
      if (state == OUTA) result <= bus_in;
    end
  always_comb begin
    dispatch = cmd_op == OP_LDA ? LOAD_A :
               (cmd_op == OP_ADD || cmd_op == OP_SUB) ? LOAD_B :
               cmd_op == OP_OUT ? OUTA : DONE;
    state_d  = state == IDLE   ? (cmd_valid ? dispatch : IDLE) :
               state == LOAD_B ? EXEC :
               state == DONE   ? IDLE : DONE;
    cmd_ready = state == IDLE;
    data_oe   = state == LOAD_A || state == LOAD_B;
    data_out  = data_oe ? data_q : 8'h00;
    nla       = !(state == LOAD_A || state == EXEC);
    nlb       = state != LOAD_B;
    ea        = state == OUTA;
    eu        = state == EXEC;
    sub       = state == EXEC && op_q == OP_SUB;
    done      = state == DONE;
    err       = state == DONE && op_q > OP_OUT;
  end
`ifdef SEQ_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cf_q <= 1'b0;
      zf_q <= 1'b0;
    end else if (state == EXEC) begin
      cf_q <= cf_in;
      zf_q <= zf_in;
    end
`else
  logic unused_flags;
  assign unused_flags = cf_in ^ zf_in;
  assign cf_q = 1'b0;
  assign zf_q = 1'b0;
`endif
endmodule

// File: tb/tb_accumulator_sequencer.sv
// tb_accumulator_sequencer: directed self-checking bench for accumulator_sequencer
module tb_accumulator_sequencer;
  logic clk = 0, rst_n = 0, cmd_valid = 0, cf_in = 0, zf_in = 0;
  logic [2:0] cmd_op = 0;
  logic [7:0] cmd_data = 0, bus_in = 0;
  logic cmd_ready, data_oe, nla, nlb, ea, eu, sub, done, err, cf_q, zf_q;
  logic [7:0] data_out, result;
  int checks = 0, errors = 0;
`ifdef SEQ_FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif
  accumulator_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .bus_in(bus_in), .cf_in(cf_in), .zf_in(zf_in), .data_out(data_out),
    .data_oe(data_oe), .nla(nla), .nlb(nlb), .ea(ea), .eu(eu), .sub(sub), .done(done), .err(err),
    .result(result), .cf_q(cf_q), .zf_q(zf_q)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    chk("bus_excl", 8'(data_oe + ea + eu) <= 1, 8'd1);
  endtask
  task automatic issue(input logic [2:0] op, input logic [7:0] d);
    cmd_valid = 1;
    cmd_op = op;
    cmd_data = d;
    step();
    cmd_valid = 0;
  endtask
  initial begin
    #3;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_result", result, 8'h00);
    chk("rst_done", done, 0);
    chk("rst_nla", nla, 1);
    chk("rst_nlb", nlb, 1);
    chk("rst_cf", cf_q, 0);
    @(posedge clk);
    #1 rst_n = 1;
    step();
    chk("post_rst_ready", cmd_ready, 1);
    issue(3'd1, 8'h25);
    chk("lda_oe", data_oe, 1);
    chk("lda_data", data_out, 8'h25);
    chk("lda_nla", nla, 0);
    chk("lda_busy", cmd_ready, 0);
    chk("lda_done_early", done, 0);
    step();
    chk("lda_done", done, 1);
    chk("lda_err", err, 0);
    chk("lda_oe_off", data_oe, 0);
    step();
    chk("lda_idle", cmd_ready, 1);
    chk("lda_done_pulse", done, 0);
    issue(3'd2, 8'h10);
    cmd_valid = 1;
    cmd_op = 3'd4;
    chk("add_nlb", nlb, 0);
    chk("add_data", data_out, 8'h10);
    chk("add_oe", data_oe, 1);
    chk("add_busy", cmd_ready, 0);
    step();
    chk("add_eu", eu, 1);
    chk("add_nla", nla, 0);
    chk("add_sub", sub, 0);
    chk("add_nlb_off", nlb, 1);
    chk("add_ignored_ea", ea, 0);
    step();
    chk("add_done", done, 1);
    chk("add_cf", cf_q, 0);
    chk("add_zf", zf_q, 0);
    cmd_valid = 0;
    step();
    chk("add_idle", cmd_ready, 1);
    chk("add_no_out", ea, 0);
    issue(3'd3, 8'h25);
    cf_in = 1;
    zf_in = 1;
    chk("sub_lb_sub", sub, 0);
    chk("sub_nlb", nlb, 0);
    chk("sub_data", data_out, 8'h25);
    step();
    chk("sub_exec_sub", sub, 1);
    chk("sub_eu", eu, 1);
    step();
    cf_in = 0;
    zf_in = 0;
    chk("sub_done", done, 1);
    chk("sub_done_sub", sub, 0);
    chk("sub_cf", cf_q, FL);
    chk("sub_zf", zf_q, FL);
    step();
    issue(3'd4, 8'h00);
    bus_in = 8'h3C;
    chk("out_ea", ea, 1);
    chk("out_oe", data_oe, 0);
    chk("out_done_early", done, 0);
    step();
    bus_in = 8'hFF;
    chk("out_done", done, 1);
    chk("out_ea_off", ea, 0);
    chk("out_result", result, 8'h3C);
    step();
    issue(3'd0, 8'h99);
    chk("nop_done", done, 1);
    chk("nop_err", err, 0);
    chk("nop_result", result, 8'h3C);
    chk("nop_cf", cf_q, FL);
    step();
    issue(3'd7, 8'h55);
    chk("ill_done", done, 1);
    chk("ill_err", err, 1);
    chk("ill_nla", nla, 1);
    chk("ill_nlb", nlb, 1);
    chk("ill_oe", data_oe, 0);
    chk("ill_data", data_out, 8'h00);
    step();
    chk("ill_idle", cmd_ready, 1);
    chk("ill_err_off", err, 0);
    issue(3'd2, 8'h01);
    cf_in = 1;
    step();
    chk("rx_eu", eu, 1);
    #2 rst_n = 0;
    #1;
    chk("rx_eu_off", eu, 0);
    chk("rx_nla", nla, 1);
    chk("rx_ready", cmd_ready, 1);
    chk("rx_result", result, 8'h00);
    chk("rx_cf", cf_q, 0);
    chk("rx_zf", zf_q, 0);
    chk("rx_done", done, 0);
    #1 rst_n = 1;
    cf_in = 0;
    step();
    chk("rx_post_ready", cmd_ready, 1);
    chk("rx_post_eu", eu, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
